pipe_stall_ctrl: RTL and testbench

- Central stall sequencer for the 5-stage MIPS pipeline (PC/IF/ID/EX/MEM/WB).
- Merges ID load-use requests, EX multi-cycle divide requests and MEM data-SRAM wait requests into the 6-bit stall bus that every stage register consumes.
- Owns the divide-busy sequencing: holds the front of the pipe for the whole divide and enforces a cycle-limit watchdog.
- Maintains a stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 93 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: merges ID/EX/MEM stall requests into the 6-bit stall
// bus, tracks divide-busy with a watchdog, and counts stalled cycles.
module pipe_stall_ctrl #(
   parameter int unsigned DIV_CYCLES = 33,
   parameter int unsigned CNT_WD     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              div_start,
   input  logic              div_ready,
   input  logic              stallreq_mem,
   output logic [5:0]        stall,
   output logic              div_busy,
   output logic              div_timeout,
   output logic [CNT_WD-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV_WAIT = 2'd1,
      DRAIN    = 2'd2
   } state_t;

   localparam logic [5:0] PAT_MEM  = 6'b011111;
   localparam logic [5:0] PAT_EX   = 6'b001111;
   localparam logic [5:0] PAT_ID   = 6'b000111;
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   state_t     state;
   logic [7:0] div_cnt;
   logic       ex_req;

   // EX holds while a divide is outstanding; the result cycle itself lets EX advance.
   always_comb begin
      ex_req = 1'b0;
      if (state == DIV_WAIT)
         ex_req = !div_ready;
      else
         ex_req = div_start && !div_ready;
   end

   always_comb begin
      stall = '0;
      if (!rst)
         stall = '0;
      else if (stallreq_mem)
         stall = PAT_MEM;
      else if (ex_req)
         stall = PAT_EX;
      else if (stallreq_id)
         stall = PAT_ID;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         div_cnt      <= '0;
         div_busy     <= 1'b0;
         div_timeout  <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (stall != 6'b000000)
            stall_cycles <= stall_cycles + 1'b1;

         case (state)
            DIV_WAIT: begin
               div_cnt <= div_cnt - 1'b1;
               if (div_ready) begin
                  state    <= DRAIN;
                  div_busy <= 1'b0;
               end else if (div_cnt == 8'd0) begin
                  state       <= DRAIN;
                  div_busy    <= 1'b0;
                  div_timeout <= 1'b1;
               end
            end
            default: begin
               // RUN and DRAIN accept a new divide identically.
               if (div_start && !div_ready) begin
                  state    <= DIV_WAIT;
                  div_busy <= 1'b1;
                  div_cnt  <= DIV_LOAD;
               end else begin
                  state    <= RUN;
                  div_busy <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then a randomized
// run, all checked against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

   localparam int unsigned DIV_CYCLES = 6;
   localparam int unsigned CNT_WD     = 8;

   logic              clk;
   logic              rst;
   logic              stallreq_id;
   logic              div_start;
   logic              div_ready;
   logic              stallreq_mem;
   logic [5:0]        stall;
   logic              div_busy;
   logic              div_timeout;
   logic [CNT_WD-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   // model: divide outstanding, cycles spent waiting, sticky timeout, stall count
   bit                m_busy;
   int                m_age;
   bit                m_to;
   logic [CNT_WD-1:0] m_cnt;

   pipe_stall_ctrl #(
      .DIV_CYCLES(DIV_CYCLES),
      .CNT_WD    (CNT_WD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stallreq_id (stallreq_id),
      .div_start   (div_start),
      .div_ready   (div_ready),
      .stallreq_mem(stallreq_mem),
      .stall       (stall),
      .div_busy    (div_busy),
      .div_timeout (div_timeout),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [5:0] exp_stall(input bit id, input bit st, input bit rdy, input bit mem);
      bit ex;
      ex = m_busy ? !rdy : (st && !rdy);
      if (mem)     return 6'b011111;
      else if (ex) return 6'b001111;
      else if (id) return 6'b000111;
      else         return 6'b000000;
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_age  = 0;
      m_to   = 0;
      m_cnt  = '0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".busy"}, 32'(div_busy), 32'(m_busy));
      chk({tag, ".timeout"}, 32'(div_timeout), 32'(m_to));
      chk({tag, ".cycles"}, 32'(stall_cycles), 32'(m_cnt));
   endtask

   // Entered at posedge+1; applies inputs, checks, crosses one edge, updates model.
   task automatic step(input string tag, input bit id, input bit st, input bit rdy, input bit mem);
      logic [5:0] es;
      stallreq_id  = id;
      div_start    = st;
      div_ready    = rdy;
      stallreq_mem = mem;
      #3;
      es = exp_stall(id, st, rdy, mem);
      chk({tag, ".stall"}, 32'(stall), 32'(es));
      check_regs(tag);
      @(posedge clk);
      #1;
      if (es != 6'b0) m_cnt = m_cnt + 1'b1;
      if (m_busy) begin
         m_age++;
         if (rdy) m_busy = 0;
         else if (m_age == DIV_CYCLES) begin
            m_busy = 0;
            m_to   = 1;
         end
      end else if (st && !rdy) begin
         m_busy = 1;
         m_age  = 0;
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted mid-cycle with requests still active.
   task automatic async_reset(input string tag);
      stallreq_id  = 1;
      stallreq_mem = 0;
      div_start    = 0;
      div_ready    = 0;
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      check_regs(tag);
      stallreq_id = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst          = 1'b0;
      stallreq_id  = 0;
      div_start    = 0;
      div_ready    = 0;
      stallreq_mem = 0;
      model_reset();
      #2;
      chk("reset.stall", 32'(stall), 32'd0);
      check_regs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      idle("idle", 10);

      step("id1", 1, 0, 0, 0);
      idle("id1_after", 2);

      // divide with result 5 cycles after start
      step("div5_start", 0, 1, 0, 0);
      idle("div5_wait", 4);
      step("div5_ready", 0, 0, 1, 0);
      idle("div5_drain", 2);

      // zero-cycle divide
      step("div0", 0, 1, 1, 0);
      idle("div0_after", 2);

      // watchdog: never ready, then a second divide accepted
      step("wd_start", 0, 1, 0, 0);
      idle("wd_wait", 9);
      step("wd_start2", 0, 1, 0, 0);
      idle("wd2_wait", 2);
      step("wd2_ready", 0, 0, 1, 0);
      step("drain_start", 0, 1, 0, 0);
      step("drain_div_ready", 0, 0, 1, 0);
      idle("wd_after", 2);

      async_reset("rst1");

      // MEM and ID during a divide, MEM still held across the ready cycle
      step("mem_start", 0, 1, 0, 0);
      step("mem_id", 1, 0, 0, 1);
      step("mem_id2", 1, 0, 0, 1);
      step("id_only", 1, 0, 0, 0);
      step("mem_ready", 0, 0, 1, 1);
      step("mem_drain", 1, 0, 0, 1);
      idle("mem_after", 2);

      // reset three cycles into a divide
      step("rd_start", 0, 1, 0, 0);
      idle("rd_wait", 2);
      async_reset("rst2");
      step("rd_restart", 0, 1, 0, 0);
      idle("rd_rewait", 2);
      step("rd_reready", 0, 0, 1, 0);
      idle("rd_after", 2);

      // randomized traffic; long enough to wrap the 8-bit stall counter
      for (int i = 0; i < 600; i++) begin
         step("rand",
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL timeout simulation did not finish");
   end

endmodule
